// File: rtl/spi_reg_controller_if.sv
// Request handshake and SPI pin bundle for spi_reg_controller.
// master = requester/bench side, slave = the controller.
interface spi_reg_controller_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic       busy;
   logic       done;

   modport master (
      output req_valid, req_write, req_addr, req_data,
      input  req_ready, sclk, copi, ncs, busy, done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data,
      output req_ready, sclk, copi, ncs, busy, done
   );
endinterface

// File: rtl/spi_reg_controller.sv
// Mode-0 SPI initiator: one 16-bit {rw, addr[6:0], data[7:0]} frame per request, MSB first.
//
// state    | meaning
// IDLE     | ncs high, ready for a request
// SETUP    | ncs low, bit15 on copi, sclk low for CLK_DIV cycles
// SCK_HI   | sclk high, peripheral samples copi
// SCK_LO   | sclk low, copi advances; after bit 0 this is the ncs hold phase
// GAP      | ncs high inter-frame gap, done pulses in its first cycle
module spi_reg_controller #(
   parameter int CLK_DIV = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   spi_reg_controller_if.slave bus
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_SCK_HI = 3'd2;
   localparam logic [2:0] S_SCK_LO = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [4:0]    bit_q, bit_d;
   logic [15:0]   sh_q, sh_d;
   logic          done_d;
   logic          div_wrap;
   logic          active_d;

   logic sclk_q, copi_q, ncs_q, busy_q, done_q, ready_q;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      done_d   = 1'b0;
      div_wrap = (div_q == DIV_MAX);

      if (state_q != S_IDLE) begin
         div_d = div_wrap ? '0 : div_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.req_valid && ready_q) begin
               state_d = S_SETUP;
               sh_d    = {bus.req_write, bus.req_addr, bus.req_data};
               bit_d   = '0;
               div_d   = '0;
            end
         end
         S_SETUP: begin
            if (div_wrap) state_d = S_SCK_HI;
         end
         S_SCK_HI: begin
            if (div_wrap) begin
               state_d = S_SCK_LO;
               // last bit stays on copi through the chip-select hold phase
               if (bit_q != 5'd15) sh_d = {sh_q[14:0], 1'b0};
            end
         end
         S_SCK_LO: begin
            if (div_wrap) begin
               if (bit_q == 5'd15) begin
                  state_d = S_GAP;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_SCK_HI;
                  bit_d   = bit_q + 5'd1;
               end
            end
         end
         S_GAP: begin
            if (div_wrap) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      active_d = (state_d == S_SETUP) || (state_d == S_SCK_HI) || (state_d == S_SCK_LO);
   end

   // Outputs are decoded from the next state so the pins are flop outputs aligned with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         ncs_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         sclk_q  <= (state_d == S_SCK_HI);
         copi_q  <= active_d ? sh_d[15] : 1'b0;
         ncs_q   <= ~active_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= done_d;
         ready_q <= (state_d == S_IDLE);
      end
   end

   assign bus.sclk      = sclk_q;
   assign bus.copi      = copi_q;
   assign bus.ncs       = ncs_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.req_ready = ready_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench for spi_reg_controller: frame scoreboard, peripheral model, timing sequences.
module tb_spi_reg_controller;

   localparam int CLK_DIV = 4;
   localparam int TMO     = 50 * CLK_DIV;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_reg_controller_if ifc ();

   spi_reg_controller #(.CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   typedef struct {
      logic        w;
      logic [6:0]  a;
      logic [7:0]  d;
      logic [15:0] frame;
   } vec_t;

   vec_t        vecs[6];
   logic [15:0] sb_q[$];
   logic [7:0]  regs[128];
   logic [7:0]  exp_regs[128];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: decodes frames on rising sclk, compares against the scoreboard, models the peripheral.
   initial begin
      logic [15:0] mon_sh;
      logic [15:0] exp_f;
      int          mon_bits;
      int          gap_cnt;
      bit          seen_frame;
      logic        prev_sclk, prev_ncs, prev_copi;
      mon_sh = '0; mon_bits = 0; gap_cnt = 0; seen_frame = 0;
      prev_sclk = 1'b0; prev_ncs = 1'b1; prev_copi = 1'b0;
      for (int i = 0; i < 128; i++) regs[i] = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_bits = 0;
         end else begin
            if (ifc.done) done_cnt++;
            if (ifc.copi !== prev_copi) check("copi_changes_while_sclk_low", ifc.sclk, 0);
            if (ifc.sclk && !prev_sclk && !ifc.ncs) begin
               mon_sh = {mon_sh[14:0], ifc.copi};
               mon_bits++;
            end
            if (!ifc.ncs && prev_ncs && seen_frame)
               check("ncs_gap_ge_div_plus_1", int'(gap_cnt >= CLK_DIV + 1), 1);
            if (ifc.ncs) gap_cnt++;
            if (ifc.ncs && !prev_ncs) begin
               check("frame_bits", mon_bits, 16);
               check("scoreboard_has_entry", int'(sb_q.size() != 0), 1);
               if (sb_q.size() != 0) begin
                  exp_f = sb_q.pop_front();
                  check("frame_value", mon_sh, exp_f);
               end
               if (mon_bits == 16 && mon_sh[15]) regs[mon_sh[14:8]] = mon_sh[7:0];
               mon_bits   = 0;
               gap_cnt    = 1;
               seen_frame = 1;
            end
         end
         prev_sclk = ifc.sclk;
         prev_ncs  = ifc.ncs;
         prev_copi = ifc.copi;
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge with req_valid still high.
   task automatic drive_req(input logic w, input logic [6:0] a, input logic [7:0] d,
                            input logic [15:0] exp);
      int n = 0;
      ifc.req_valid = 1'b1;
      ifc.req_write = w;
      ifc.req_addr  = a;
      ifc.req_data  = d;
      while (!ifc.req_ready && n < TMO) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", ifc.req_ready, 1);
      sb_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!ifc.req_ready && n < TMO) begin
         @(negedge clk);
         n++;
      end
      check("return_to_idle", ifc.req_ready, 1);
   endtask

   initial begin
      int k, ncs_low, done_hits, done_k, ready_k, first_rise, rises, busy_n, d_before, n, bad;
      logic ps;

      if (CLK_DIV < 4) begin
         $display("FAIL cfg_clk_div: CLK_DIV=%0d below minimum 4", CLK_DIV);
         $fatal(1);
      end

      vecs[0] = '{1'b1, 7'h04, 8'h80, 16'h8480};
      vecs[1] = '{1'b1, 7'h00, 8'hFF, 16'h80FF};
      vecs[2] = '{1'b1, 7'h55, 8'h3C, 16'hD53C};
      vecs[3] = '{1'b0, 7'h12, 8'h34, 16'h1234};
      vecs[4] = '{1'b1, 7'h7E, 8'h01, 16'hFE01};
      vecs[5] = '{1'b1, 7'h01, 8'h96, 16'h8196};
      for (int i = 0; i < 128; i++) exp_regs[i] = 8'h00;

      rst_n = 1'b0;
      ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_addr = '0; ifc.req_data = '0;

      // 1: reset values, then 20 idle cycles
      @(negedge clk);
      check("reset_outputs", {ifc.ncs, ifc.sclk, ifc.copi, ifc.req_ready, ifc.busy, ifc.done}, 6'b100100);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_outputs", {ifc.ncs, ifc.sclk, ifc.copi, ifc.req_ready, ifc.busy, ifc.done}, 6'b100100);
      end
      check("idle_no_done", done_cnt, 0);

      // 2: timing of one write frame, accept edge = cycle 0
      ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_addr = 7'h04; ifc.req_data = 8'h80;
      sb_q.push_back(16'h8480);
      exp_regs[7'h04] = 8'h80;
      @(posedge clk);
      ncs_low = 0; done_hits = 0; done_k = 0; ready_k = 0; first_rise = 0; rises = 0; ps = 1'b0;
      for (k = 1; k <= 36 * CLK_DIV; k++) begin
         @(negedge clk);
         if (k == 1) ifc.req_valid = 1'b0;
         if (!ifc.ncs) ncs_low++;
         if (ifc.done) begin done_hits++; done_k = k; end
         if (ifc.req_ready && ready_k == 0) ready_k = k;
         if (ifc.sclk && !ps) begin
            rises++;
            if (first_rise == 0) first_rise = k;
         end
         ps = ifc.sclk;
      end
      check("ncs_low_cycles", ncs_low, 33 * CLK_DIV);
      check("sclk_rising_edges", rises, 16);
      check("first_rise_cycle", first_rise, 1 + CLK_DIV);
      check("done_pulse_count", done_hits, 1);
      check("done_cycle", done_k, 1 + 33 * CLK_DIV);
      check("ready_cycle", ready_k, 1 + 34 * CLK_DIV);

      // 3: table of single frames through the peripheral model
      for (int i = 0; i < 6; i++) begin
         drive_req(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].frame);
         ifc.req_valid = 1'b0;
         ifc.req_addr  = ~vecs[i].a;
         ifc.req_data  = ~vecs[i].d;
         if (vecs[i].w) exp_regs[vecs[i].a] = vecs[i].d;
         wait_idle();
      end
      @(negedge clk);
      check("reg0_written", regs[0], 8'hFF);

      // 4: back-to-back with req_valid held high; second request set mid-frame
      drive_req(1'b1, 7'h02, 8'hA5, 16'h82A5);
      drive_req(1'b1, 7'h03, 8'h5A, 16'h835A);
      ifc.req_valid = 1'b0;
      ifc.req_addr  = 7'h11;
      ifc.req_data  = 8'h00;
      exp_regs[7'h02] = 8'hA5;
      exp_regs[7'h03] = 8'h5A;
      wait_idle();
      @(negedge clk);
      check("b2b_reg2", regs[7'h02], 8'hA5);
      check("b2b_reg3", regs[7'h03], 8'h5A);

      // 5: reset after the 7th rising sclk edge
      drive_req(1'b1, 7'h10, 8'h11, 16'h9011);
      ifc.req_valid = 1'b0;
      rises = 0; n = 0; ps = ifc.sclk;
      while (rises < 7 && n < TMO) begin
         @(negedge clk);
         if (ifc.sclk && !ps) rises++;
         ps = ifc.sclk;
         n++;
      end
      check("reached_7th_edge", rises, 7);
      d_before = done_cnt;
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {ifc.ncs, ifc.sclk, ifc.copi, ifc.req_ready, ifc.busy}, 5'b10010);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      repeat (3 * CLK_DIV) @(negedge clk);
      check("abort_no_done", done_cnt, d_before);
      check("abort_no_write", regs[7'h10], 8'h00);
      drive_req(1'b1, 7'h11, 8'h22, 16'h9122);
      ifc.req_valid = 1'b0;
      exp_regs[7'h11] = 8'h22;
      wait_idle();
      @(negedge clk);
      check("post_abort_write", regs[7'h11], 8'h22);

      // 6: read frame, busy duration, registers untouched
      drive_req(1'b0, 7'h7F, 8'h00, 16'h7F00);
      ifc.req_valid = 1'b0;
      busy_n = 0;
      while (ifc.busy && busy_n < TMO) begin
         busy_n++;
         @(negedge clk);
      end
      check("read_busy_cycles", busy_n, 34 * CLK_DIV);
      wait_idle();
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 128; i++) if (regs[i] !== exp_regs[i]) bad++;
      check("model_regs_match", bad, 0);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
